poly_reduce_ctrl: RTL
=====================

POLY_REDUCE_CTRL -- requirements
Module: poly_reduce_ctrl

Interface
REQ-001 Parameters SHALL be: KYBER_Q, 3329, modulus; WIDTH, 16, coefficient width (signed); LOG_N, 8, log2 coefficients per polynomial; BASE_W, 2, polynomial-slot select width.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports: clk  in  1  clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request to reduce one polynomial; sampled only in IDLE.
REQ-006 base  in  BASE_W  polynomial slot; latched when start is accepted.
REQ-007 busy  out  1  high from accept cycle until done pulse inclusive.
REQ-008 done  out  1  single-cycle completion pulse.
REQ-009 mem_rd_en  out  1  coefficient read strobe.
REQ-010 mem_rd_addr  out  BASE_W+LOG_N  read address {base_q, idx}.
REQ-011 mem_rd_data  in  WIDTH  signed read data; valid exactly 1 cycle after mem_rd_en.
REQ-012 mem_we  out  1  write strobe.
REQ-013 mem_wr_addr  out  BASE_W+LOG_N  write address.
REQ-014 mem_wr_data  out  WIDTH  reduced coefficient.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE -> RUN when start=1; base latched into base_q, read index cleared to 0, busy asserted next cycle.
REQ-017 RUN: mem_rd_en=1 every cycle, mem_rd_addr={base_q, idx}, idx increments by 1; after idx=2^LOG_N-1 is issued, RUN -> DRAIN.
REQ-018 DRAIN: no reads; remains 2 cycles until last write issued, then -> DONE.
REQ-019 DONE: done=1 for exactly one cycle, busy=1 that cycle, then -> IDLE with busy=0.
REQ-020 Pipeline: read issued cycle c; data reduced combinationally in c+1 and registered with its address; mem_we=1 with that address/result in c+2.
REQ-021 Timing from accept edge (cycle 0): read of index i in cycle i+1; write of index i in cycle i+3; last write cycle 2^LOG_N+2; done in cycle 2^LOG_N+3.
REQ-022 Each index SHALL be written exactly once, in ascending order, to the same address it was read from; no gaps in mem_we during the write burst.
REQ-023 Reduction: t = (v*a + 2^25) arithmetically shifted right 26, v = floor((2^26 + KYBER_Q/2)/KYBER_Q) = 20159, 32-bit signed product; result = a - t*KYBER_Q truncated to WIDTH signed.
REQ-024 For any signed 16-bit a, result SHALL be congruent to a mod KYBER_Q and lie in [-1664, 1664].
REQ-025 start while busy (RUN, DRAIN, DONE) SHALL be ignored, not queued; base changes while busy SHALL not affect addresses.
REQ-026 start asserted in the done cycle SHALL be ignored; a new start is accepted in the following IDLE cycle.
REQ-027 idx wraps only at the RUN -> DRAIN transition; read address SHALL never leave slot base_q.
REQ-028 mem_rd_en and mem_we SHALL be 0 in IDLE and DONE; mem_rd_en 0 in DRAIN.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, mem_rd_en=0, mem_we=0, addresses=0, mem_wr_data=0, idx=0, base_q=0, pipeline valids cleared.
REQ-030 Reset mid-operation SHALL abandon the polynomial; no write issued after rst_n deasserts; next start restarts at index 0.

Verification
REQ-031 Single run, base=1, memory slot 1 preloaded a[i]=i*13-1600 -> 256 writes to addresses 256..511 in cycles 3..258, done in cycle 259, each value = reference Barrett of a[i].
REQ-032 Boundary values at indices 0..5: 3329, -3329, 1664, 1665, 32767, -32768 -> written 0, 0, 1664, -1664, -523, 522.
REQ-033 start pulsed at cycles 5, 100 and at done cycle with base changed -> ignored; exactly 256 writes, all in slot latched at accept.
REQ-034 rst_n pulsed low at cycle 50 of a run -> outputs 0 immediately, no mem_we afterwards; subsequent start completes a full clean run (256 writes, done at +259).
REQ-035 Back-to-back: start held high continuously, base=0 then 3 -> second run accepted first IDLE cycle after done; both slots fully reduced, other slots untouched.

Source files
------------

// File: rtl/poly_reduce_ctrl.sv
`timescale 1ns/1ps
// poly_reduce_ctrl: streams one 2^LOG_N-coefficient polynomial out of a
// coefficient memory, Barrett-reduces each signed coefficient into the
// centred range [-(Q-1)/2, (Q-1)/2], and writes it back in place.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start, base      request and polynomial slot (sampled only in IDLE)
//   busy, done       accept..done status, single-cycle completion pulse
//   mem_rd_en/addr   read strobe and address {base_q, idx}
//   mem_rd_data      signed read data, valid one cycle after mem_rd_en
//   mem_we/wr_addr/wr_data  write strobe, address and reduced value
module poly_reduce_ctrl #(
    parameter int          KYBER_Q = 3329,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LOG_N   = 8,
    parameter int unsigned BASE_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BASE_W-1:0]         base,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd_en,
    output logic [BASE_W+LOG_N-1:0]   mem_rd_addr,
    input  logic signed [WIDTH-1:0]   mem_rd_data,
    output logic                      mem_we,
    output logic [BASE_W+LOG_N-1:0]   mem_wr_addr,
    output logic signed [WIDTH-1:0]   mem_wr_data
);

    localparam int unsigned      ADDR_W    = BASE_W + LOG_N;
    localparam logic [LOG_N-1:0] IDX_LAST  = LOG_N'((1 << LOG_N) - 1);
    localparam int signed        V_BARRETT = ((1 << 26) + KYBER_Q / 2) / KYBER_Q;
    localparam int signed        ROUND     = 1 << 25;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [LOG_N-1:0]   idx_q, idx_d;
    logic [LOG_N-1:0]   idx_nxt_c;
    logic [BASE_W-1:0]  base_q, base_d;
    logic               drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;

    // Pipeline: stage 1 tracks the read in flight, stage 2 holds the write.
    logic               rvld_q;
    logic [ADDR_W-1:0]  raddr_q;
    logic               we_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic signed [WIDTH-1:0] wr_data_q;

    int signed               prod_c;
    int signed               t_c;
    logic signed [WIDTH-1:0] res_c;

    // Barrett reduction of the returning coefficient.
    always_comb begin
        prod_c = int'(mem_rd_data) * V_BARRETT;
        t_c    = (prod_c + ROUND) >>> 26;
        res_c  = WIDTH'(int'(mem_rd_data) - t_c * KYBER_Q);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        idx_nxt_c = idx_q + LOG_N'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    base_d    = base;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {base, LOG_N'(0)};
                end
            end
            RUN: begin
                // idx_q is the index being read this cycle.
                if (idx_q == IDX_LAST) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    drain_d = 1'b0;
                end else begin
                    idx_d     = idx_nxt_c;
                    rd_en_d   = 1'b1;
                    rd_addr_d = {base_q, idx_nxt_c};
                end
            end
            DRAIN: begin
                // Two cycles let the last read reach the write stage.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    drain_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state, control outputs and datapath pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rvld_q    <= 1'b0;
            raddr_q   <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rvld_q    <= rd_en_q;
            raddr_q   <= rd_addr_q;
            we_q      <= rvld_q;
            if (rvld_q) begin
                wr_addr_q <= raddr_q;
                wr_data_q <= res_c;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_we      = we_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;

endmodule
